// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access stage: size codes, FSM states,
// default bus timeout and lane helpers.
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  // Offset bits that survive alignment to the access size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b111;
      SZ_H:    return 3'b110;
      SZ_W:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] be_base(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction
endpackage

// File: rtl/dmem_access_unit_load_align.sv
// Combinational load aligner: lane-shifts a 64-bit read word and sign/zero
// extends the selected byte, half, word or double.
module load_align
  import dmem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [63:0] result
);
  logic [63:0] sh;

  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    result = {{56{sign_ext & sh[7]}},  sh[7:0]};
      SZ_H:    result = {{48{sign_ext & sh[15]}}, sh[15:0]};
      SZ_W:    result = {{32{sign_ext & sh[31]}}, sh[31:0]};
      default: result = sh;
    endcase
  end
endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: stalls the core while a ready-handshaked 64-bit
// access runs. Define MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] read_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e      state;
  logic [CW-1:0] cnt;
  logic [2:0]  off, off_m, off_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        misalign;
  logic [63:0] ld_data;

  assign off   = address[2:0];
  assign off_m = off & align_mask(size);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (off != off_m);
`else
  assign misalign = 1'b0;
`endif

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .off      (off_q),
    .size     (size_q),
    .sign_ext (sext_q),
    .result   (ld_data)
  );

  always_comb begin
    stall = 1'b0;
    if (!reset)
      case (state)
        ST_IDLE: stall = mem_read | mem_write;
        ST_BUSY: stall = 1'b1;
        default: stall = 1'b0;
      endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      read_data  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      off_q      <= '0;
      size_q     <= SZ_B;
      sext_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (mem_read | mem_write) begin
            if ((mem_read & mem_write) | misalign) begin
              // Rejected requests never reach the bus.
              state     <= ST_DONE;
              done      <= 1'b1;
              fault     <= 1'b1;
              read_data <= '0;
            end else begin
              state      <= ST_BUSY;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {address[ADDR_W-1:3], 3'b000};
              dmem_be    <= be_base(size) << off_m;
              dmem_wdata <= write_data << {off_m, 3'b000};
              off_q      <= off_m;
              size_q     <= size;
              sext_q     <= sign_ext;
            end
          end
        end
        ST_BUSY: begin
          if (dmem_ready) begin
            state     <= ST_DONE;
            dmem_req  <= 1'b0;
            done      <= 1'b1;
            fault     <= 1'b0;
            read_data <= dmem_we ? '0 : ld_data;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state     <= ST_DONE;
            dmem_req  <= 1'b0;
            done      <= 1'b1;
            fault     <= 1'b1;
            read_data <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: byte-addressed reference model,
// randomized memory responder, decoupled request/response monitors.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  localparam int T = 256;
  localparam int unsigned NEVER = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, sign_ext;
  logic [1:0]  size;
  logic [63:0] address, write_data;
  logic        stall, done, fault;
  logic [63:0] read_data;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;

  dmem_access_unit #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext), .address(address), .write_data(write_data),
    .stall(stall), .done(done), .fault(fault), .read_data(read_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit we; logic [63:0] addr; logic [7:0] be; logic [63:0] wdata;} req_t;
  typedef struct {bit fault; logic [63:0] rdata; longint done_cyc;} rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int errors = 0;
  int unsigned wait_cfg = 0;

  logic [7:0] ref_mem [logic [63:0]];
  logic [7:0] dev_mem [logic [63:0]];

  function automatic logic [7:0] fill(input logic [63:0] a);
    return 8'(a * 37) ^ 8'(a >> 8) ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  function automatic logic [7:0] dev_rd(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : fill(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Memory device: answers after wait_cfg BUSY cycles; random noise when idle.
  initial begin
    int unsigned wcnt;
    wcnt = 0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_req && !reset) begin
        dmem_ready = 1'b0;
        if (wcnt == wait_cfg) begin
          dmem_ready = 1'b1;
          for (int i = 0; i < 8; i++) dmem_rdata[8*i +: 8] = dev_rd(dmem_addr + 64'(i));
          if (dmem_we)
            for (int i = 0; i < 8; i++)
              if (dmem_be[i]) dev_mem[dmem_addr + 64'(i)] = dmem_wdata[8*i +: 8];
        end
        wcnt++;
      end else begin
        wcnt = 0;
        dmem_ready = ($urandom_range(0, 3) == 0);
        dmem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a request or completes.
  initial begin
    bit prev_req;
    req_t r;
    rsp_t p;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dmem_req && !prev_req) begin
          if (req_q.size() == 0) fail("unexpected_req");
          else begin
            r = req_q.pop_front();
            chk("req_we", dmem_we, r.we);
            chk("req_addr", dmem_addr, r.addr);
            chk("req_be", dmem_be, r.be);
            chk("req_wdata", dmem_wdata, r.wdata);
          end
        end
        if (dmem_req) chk("stall_busy", stall, 1);
        if (done) begin
          chk("stall_done", stall, 0);
          if (rsp_q.size() == 0) fail("unexpected_done");
          else begin
            p = rsp_q.pop_front();
            chk("rsp_fault", fault, p.fault);
            chk("rsp_rdata", read_data, p.rdata);
            chk("rsp_cycle", 64'(cyc), 64'(p.done_cyc));
          end
        end
      end
      prev_req = dmem_req;
    end
  end

  // Drive one access, push the model's expectations, wait for completion.
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                        input logic [63:0] a, input logic [63:0] wd, input int unsigned waits);
    int nb, eoff, n;
    bit trap, tmo;
    logic [63:0] base, ea, val;
    req_t r;
    @(posedge clk); #1;
    nb   = 1 << sz;
    eoff = int'(a[2:0]) - (int'(a[2:0]) % nb);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (int'(a[2:0]) % nb) != 0;
`endif
    tmo  = (waits >= T);
    base = {a[63:3], 3'b000};
    ea   = base + 64'(eoff);
    if ((rd && wr) || trap) begin
      rsp_q.push_back('{1'b1, 64'd0, cyc + 1});
    end else begin
      r.we = wr; r.addr = base; r.be = 8'(((1 << nb) - 1) << eoff);
      r.wdata = wd << (8 * eoff);
      req_q.push_back(r);
      val = '0;
      if (wr && !tmo)
        for (int i = 0; i < nb; i++) ref_mem[ea + 64'(i)] = wd[8*i +: 8];
      if (rd) begin
        for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_rd(ea + 64'(i));
        if (sx && val[8*nb-1])
          for (int i = 8*nb; i < 64; i++) val[i] = 1'b1;
      end
      if (tmo) rsp_q.push_back('{1'b1, 64'd0, cyc + T + 1});
      else     rsp_q.push_back('{1'b0, val, cyc + 2 + waits});
    end
    wait_cfg = waits;
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    address = a; write_data = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < T + 10);
    if (!done) fail("done_timeout");
  endtask

  initial begin
    logic [1:0]  sz;
    int          k;
    reset = 1'b1;
    mem_read = 0; mem_write = 0; size = SZ_B; sign_ext = 0;
    address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {stall, done, fault, dmem_req, dmem_we}, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    @(posedge clk); #1 reset = 1'b0;

    access(0, 1, SZ_D, 0, 64'h100, 64'h1122334455667788, 0);
    access(1, 0, SZ_D, 0, 64'h100, 64'h0, 0);
    access(0, 1, SZ_D, 0, 64'h100, 64'h80FF, 0);
    access(1, 0, SZ_B, 1, 64'h100, 64'h0, 0);
    access(1, 0, SZ_B, 0, 64'h101, 64'h0, 1);
    access(0, 1, SZ_H, 0, 64'h106, 64'hBEEF, 2);
    access(1, 0, SZ_H, 1, 64'h106, 64'h0, 0);
    access(1, 0, SZ_W, 0, 64'h102, 64'h0, 0);
    access(1, 0, SZ_D, 1, 64'h108, 64'h0, NEVER);
    access(0, 1, SZ_W, 0, 64'h10C, 64'hCAFE_F00D, NEVER);
    access(1, 0, SZ_W, 1, 64'h10C, 64'h0, T - 1);
    access(1, 1, SZ_W, 0, 64'h100, 64'h0, 0);

    // Reset in the third BUSY cycle abandons the request.
    req_q.push_back('{1'b0, 64'h200, 8'hFF, 64'h0});
    wait_cfg = 10;
    @(posedge clk); #1;
    mem_read = 1; mem_write = 0; size = SZ_D; sign_ext = 0;
    address = 64'h200; write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; mem_read = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_req", dmem_req, 0);
    chk("abort_stall", stall, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      k  = $urandom_range(0, 19);
      access(k < 10, k == 0 || k >= 10, sz, 1'($urandom_range(0, 1)),
             64'h100 + 64'($urandom_range(0, 63)), {$urandom, $urandom},
             $urandom_range(0, 3));
    end

    @(posedge clk); #1 mem_read = 0; mem_write = 0;
    repeat (5) @(posedge clk);
    chk("req_q_drained", 64'(req_q.size()), 0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory access stage directly downstream of the ALU in the single-cycle datapath. Takes the ALU-computed effective address with load/store control, drives a ready-handshaked 64-bit data-memory port, and stalls the core until the access completes. On loads it returns the aligned, sign- or zero-extended result for register write-back. It also flags bus timeouts and illegal requests.

## Interface
- ADDR_W, 64, effective-address width; matches the ALU result width.
- DATA_W, 64, register and memory data width; fixed at 64 (8 byte lanes).
- TIMEOUT_CYCLES, 256, maximum number of BUSY cycles to wait for dmem_ready before faulting.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  load request; held stable by the core while stall=1.
- mem_write  in  1  store request; held stable by the core while stall=1.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
- address  in  ADDR_W  effective address from the ALU result.
- write_data  in  DATA_W  store data, taken from the low bits.
- stall  out  1  combinational; holds PC and pipeline state.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; access failed.
- read_data  out  DATA_W  load result, valid with done.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  doubleword-aligned address (low 3 bits = 0).
- dmem_be  out  8  byte enables.
- dmem_wdata  out  DATA_W  lane-shifted store data.
- dmem_ready  in  1  memory accepted the write or returned read data this cycle.
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = mem_read | mem_write.
  - On a request edge, register address[ADDR_W-1:3]<<3, byte enables, shifted data, size, sign_ext and offset, then go to BUSY.
- BUSY:
  - dmem_req=1, stall=1; a timeout counter increments each cycle.
  - dmem_ready=1 → capture the result and go to DONE with fault=0.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready → go to DONE with fault=1 and read_data=0.
- DONE:
  - done=1, stall=0; the core advances PC on this edge.
  - Still-asserted request inputs are ignored in DONE.
  - Next state is always IDLE.
- Illegal request (mem_read and mem_write both 1): IDLE→DONE directly, fault=1, no dmem_req.
- Byte lanes: off = address[2:0].
  - dmem_be = 8'h01<<off (byte), 8'h03<<off (half), 8'h0F<<off (word), 8'hFF (double).
  - dmem_wdata = write_data<<(8*off), truncated to 64 bits.
- Load: shift dmem_rdata right by 8*off, keep the size's width, then extend per sign_ext.
- Stores write read_data=0.
- Reset:
  - state=IDLE, counter=0.
  - stall, done, fault, dmem_req, dmem_we = 0; read_data, dmem_addr, dmem_be, dmem_wdata = 0.
  - Reset during BUSY drops dmem_req on the next cycle; the memory must tolerate an abandoned request.

## Timing
- Zero-wait memory: request cycle (IDLE) + BUSY cycle with ready + DONE = 3 cycles; read_data is valid in the DONE cycle.
- Each memory wait cycle adds one cycle. Maximum is 2+TIMEOUT_CYCLES cycles.
- dmem_* outputs are registered and stable throughout BUSY; dmem_req never deasserts before dmem_ready except on reset or timeout.
- If dmem_ready and the timeout fall on the same edge, ready wins (fault=0).
- The counter saturates and clears on entry to BUSY.
- dmem_ready outside BUSY is ignored.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A request whose off is not a multiple of the access size goes IDLE→DONE with fault=1 and no dmem_req.
  - Qualifying cases: half with off[0]=1; word with off[1:0]≠0; double with off≠0.
- MISALIGN_TRAP_EN undefined:
  - off is masked to size alignment before lane computation (off[0] cleared for half, off[1:0] for word, all for double).
  - The access proceeds silently on the aligned container.

## Structure
- Shared package dmem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - the state enum;
  - the default TIMEOUT_CYCLES constant.
- One combinational sub-module, load_align: inputs rdata, off, size, sign_ext; output read result. It is reusable by a future cache.

## Test plan
- Store double 0x1122334455667788 at 0x100, ready after 0 waits → dmem_addr=0x100, be=0xFF, done at cycle 3; load double back → read_data=0x1122334455667788.
- dmem_rdata=0x00000000_0000_80FF, load byte at 0x100 sign_ext=1 → 0xFFFFFFFFFFFFFFFF; at 0x101 sign_ext=0 → 0x80.
- Store half 0xBEEF at 0x106 → dmem_addr=0x100, be=0xC0, dmem_wdata[63:48]=0xBEEF.
- dmem_ready held low → fault=1 and done exactly TIMEOUT_CYCLES cycles after entering BUSY; read_data=0; stall drops in that cycle.
- Load word at 0x102 → with MISALIGN_TRAP_EN: fault=1, no dmem_req. Without it: dmem_be=0x0F, access completes normally.
- Assert reset during the 3rd BUSY cycle → next cycle dmem_req=0, stall=0, state IDLE. Assert mem_read=mem_write=1 → fault=1 done pulse, no dmem_req.
